// File: rtl/qeciphy_tgc_pkg.sv
// -----------------------------------------------------------------------------
// qeciphy_tgc_pkg
// Shared definitions for the QECIPHY traffic generator / checker:
//   - mode_e       : pattern selection (incrementing counter or PRBS31)
//   - gen_state_t  : generator FSM encoding (G_IDLE, G_SEND, G_GAP)
//   - chk_state_t  : checker FSM encoding (C_IDLE, C_SYNC, C_CHECK)
//   - PRBS31 tap positions (x^31 + x^28 + 1) and default seed
//   - prbs31_step  : one PRBS31 shift
// -----------------------------------------------------------------------------
package qeciphy_tgc_pkg;

    typedef enum logic {
        MODE_CNT  = 1'b0,
        MODE_PRBS = 1'b1
    } mode_e;

    // State encodings kept as plain localparams so existing code that decodes
    // the raw state bits keeps working.
    typedef logic [1:0] gen_state_t;
    localparam gen_state_t G_IDLE = 2'd0;
    localparam gen_state_t G_SEND = 2'd1;
    localparam gen_state_t G_GAP  = 2'd2;

    typedef logic [1:0] chk_state_t;
    localparam chk_state_t C_IDLE  = 2'd0;
    localparam chk_state_t C_SYNC  = 2'd1;
    localparam chk_state_t C_CHECK = 2'd2;

    // x^31 + x^28 + 1 taps, as bit indices into the 31-bit state.
    localparam int PRBS31_TAP_HI = 30;
    localparam int PRBS31_TAP_LO = 27;

    localparam logic [30:0] PRBS31_SEED_DEFAULT = 31'h7FFF_FFFF;

    // A nonzero state never maps to zero, so the all-zero lock-up state is
    // unreachable from any legal seed.
    function automatic logic [30:0] prbs31_step(input logic [30:0] s);
        return {s[29:0], s[PRBS31_TAP_HI] ^ s[PRBS31_TAP_LO]};
    endfunction

endpackage

// File: rtl/qeciphy_tgc_pattern.sv
// -----------------------------------------------------------------------------
// qeciphy_tgc_pattern
// Purely combinational pattern step shared by generator and checker.
// Ports:
//   mode  in  1       0 = counter, 1 = PRBS31
//   cur   in  DATA_W  current pattern state (PRBS state lives in cur[30:0])
//   nxt   out DATA_W  next pattern state
//   data  out DATA_W  data word presented for state cur
// -----------------------------------------------------------------------------
module qeciphy_tgc_pattern
    import qeciphy_tgc_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              mode,
    input  logic [DATA_W-1:0] cur,
    output logic [DATA_W-1:0] nxt,
    output logic [DATA_W-1:0] data
);

    localparam int REPS = (DATA_W + 31) / 32;

    // PRBS word is the 31-bit state zero-extended to 32 bits, replicated and
    // truncated to DATA_W (DATA_W need not be a multiple of 32).
    logic [REPS*32-1:0] prbs_rep;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        prbs_rep = {REPS{{1'b0, cur[30:0]}}};
        nxt      = '0;
        data     = cur;
        if (mode == MODE_PRBS) begin
            nxt[30:0] = prbs31_step(cur[30:0]);
            data      = prbs_rep[DATA_W-1:0];
        end else begin
            nxt = cur + 1'b1;
        end
    end

endmodule

// File: rtl/qeciphy_traffic_gen_chk.sv
// -----------------------------------------------------------------------------
// qeciphy_traffic_gen_chk
// AXI-Stream traffic generator and checker for PHY link bring-up.
// The generator emits a counter or PRBS31 stream with a programmable idle gap
// after each beat; the checker locks onto the received stream, then counts
// beats and mismatches with saturating counters.
//
// Ports:
//   ACLK, rst_n          clock, asynchronous active-low reset
//   enable, link_up      run controls (generator needs both, checker enable)
//   mode                 0 = counter, 1 = PRBS31; sampled only while idle
//   gap_len[7:0]         idle cycles after each accepted TX beat
//   clr_stats            synchronous clear of counters and err_sticky
//   tx_tdata/tvalid/tready  AXI-Stream source
//   rx_tdata/tvalid/tready  AXI-Stream sink (rx_tready tied high)
//   tx_cnt, rx_cnt, err_cnt saturating counters (CNT_W)
//   err_sticky, locked   status
//   inject_err           only with QECIPHY_TGC_ERR_INJECT_EN defined: flips
//                        bit 0 of the next accepted TX beat
//
// Build option: define QECIPHY_TGC_ERR_INJECT_EN to add error injection.
// -----------------------------------------------------------------------------
module qeciphy_traffic_gen_chk
    import qeciphy_tgc_pkg::*;
#(
    parameter int          DATA_W = 64,
    parameter int          CNT_W  = 32,
    parameter logic [30:0] SEED   = PRBS31_SEED_DEFAULT
) (
    input  logic              ACLK,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              link_up,
    input  logic              mode,
    input  logic [7:0]        gap_len,
    input  logic              clr_stats,
`ifdef QECIPHY_TGC_ERR_INJECT_EN
    input  logic              inject_err,
`endif
    output logic [DATA_W-1:0] tx_tdata,
    output logic              tx_tvalid,
    input  logic              tx_tready,
    input  logic [DATA_W-1:0] rx_tdata,
    input  logic              rx_tvalid,
    output logic              rx_tready,
    output logic [CNT_W-1:0]  tx_cnt,
    output logic [CNT_W-1:0]  rx_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              err_sticky,
    output logic              locked
);

    localparam logic [DATA_W-1:0] SEED_EXT = {{(DATA_W-31){1'b0}}, SEED};

    // ------------------------------------------------------------------ gen --
    gen_state_t        gen_state_q, gen_state_d;
    logic              arm_q, arm_d;
    logic              gen_mode_q, gen_mode_d;
    logic [DATA_W-1:0] gen_pat_q, gen_pat_d;
    logic [7:0]        gap_cnt_q, gap_cnt_d;
    logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
    logic [DATA_W-1:0] gen_nxt, gen_data;
    logic              run, tx_accept;

    assign run       = enable && link_up;
    assign tx_tvalid = (gen_state_q == G_SEND);
    assign tx_accept = tx_tvalid && tx_tready;

    qeciphy_tgc_pattern #(.DATA_W(DATA_W)) u_gen_pattern (
        .mode (gen_mode_q),
        .cur  (gen_pat_q),
        .nxt  (gen_nxt),
        .data (gen_data)
    );

    always_comb begin
        gen_state_d = gen_state_q;
        arm_d       = 1'b1;
        gen_mode_d  = gen_mode_q;
        gen_pat_d   = gen_pat_q;
        gap_cnt_d   = gap_cnt_q;
        tx_cnt_d    = tx_cnt_q;

        case (gen_state_q)
            // arm_q delays the first beat to at least two cycles after reset.
            G_IDLE: if (run && arm_q) gen_state_d = G_SEND;
            // Once valid is up, stopping waits for the handshake.
            G_SEND: if (tx_accept) begin
                if (!run) begin
                    gen_state_d = G_IDLE;
                end else if (gap_len != 8'd0) begin
                    gen_state_d = G_GAP;
                    gap_cnt_d   = gap_len;
                end
            end
            G_GAP: begin
                if (!run)                    gen_state_d = G_IDLE;
                else if (gap_cnt_q <= 8'd1)  gen_state_d = G_SEND;
                else                         gap_cnt_d   = gap_cnt_q - 8'd1;
            end
            default: gen_state_d = G_IDLE;
        endcase

        // Idle tracks the mode input and holds the restart value, so the
        // first beat after leaving idle is always 0 / SEED.
        if (gen_state_q == G_IDLE) begin
            gen_mode_d = mode;
            gen_pat_d  = (mode == MODE_PRBS) ? SEED_EXT : '0;
        end else if (gen_state_d == G_IDLE) begin
            gen_pat_d  = (gen_mode_q == MODE_PRBS) ? SEED_EXT : '0;
        end else if (tx_accept) begin
            gen_pat_d  = gen_nxt;
        end

        if (clr_stats)                           tx_cnt_d = '0;
        else if (tx_accept && (tx_cnt_q != '1))  tx_cnt_d = tx_cnt_q + 1'b1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others regardless of statement order.
    always_ff @(posedge ACLK or negedge rst_n) begin
        if (!rst_n) begin
            gen_state_q <= G_IDLE;
            arm_q       <= 1'b0;
            gen_mode_q  <= 1'b0;
            gen_pat_q   <= '0;
            gap_cnt_q   <= '0;
            tx_cnt_q    <= '0;
        end else begin
            gen_state_q <= gen_state_d;
            arm_q       <= arm_d;
            gen_mode_q  <= gen_mode_d;
            gen_pat_q   <= gen_pat_d;
            gap_cnt_q   <= gap_cnt_d;
            tx_cnt_q    <= tx_cnt_d;
        end
    end

`ifdef QECIPHY_TGC_ERR_INJECT_EN
    // A request is parked until a new beat is put on the bus, then the flip is
    // bound to that beat so tx_tdata stays stable while valid is high.
    logic inj_pend_q, inj_pend_d;
    logic inj_cur_q, inj_cur_d;
    logic new_beat;

    always_comb begin
        new_beat   = (gen_state_d == G_SEND) && ((gen_state_q != G_SEND) || tx_accept);
        inj_pend_d = inj_pend_q | inject_err;
        inj_cur_d  = inj_cur_q;
        if (new_beat) begin
            inj_cur_d  = inj_pend_q | inject_err;
            inj_pend_d = 1'b0;
        end else if (tx_accept) begin
            inj_cur_d  = 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge rst_n) begin
        if (!rst_n) begin
            inj_pend_q <= 1'b0;
            inj_cur_q  <= 1'b0;
        end else begin
            inj_pend_q <= inj_pend_d;
            inj_cur_q  <= inj_cur_d;
        end
    end

    assign tx_tdata = gen_data ^ {{(DATA_W-1){1'b0}}, inj_cur_q};
`else
    assign tx_tdata = gen_data;
`endif

    // ------------------------------------------------------------------ chk --
    chk_state_t        chk_state_q, chk_state_d;
    logic              chk_mode_q, chk_mode_d;
    logic [DATA_W-1:0] ref_q, ref_d;
    logic              locked_q, locked_d;
    logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic              err_sticky_q, err_sticky_d;
    logic [DATA_W-1:0] seed_word, chk_cur, chk_nxt, chk_data;
    logic              seed_bad, rx_inc, err_inc;

    // During sync the pattern block steps the received word, so the
    // reference is already one beat ahead when C_CHECK starts.
    assign seed_word = (chk_mode_q == MODE_PRBS) ? {{(DATA_W-31){1'b0}}, rx_tdata[30:0]}
                                                 : rx_tdata;
    assign seed_bad  = (chk_mode_q == MODE_PRBS) && (rx_tdata[30:0] == 31'd0);
    assign chk_cur   = (chk_state_q == C_SYNC) ? seed_word : ref_q;

    qeciphy_tgc_pattern #(.DATA_W(DATA_W)) u_chk_pattern (
        .mode (chk_mode_q),
        .cur  (chk_cur),
        .nxt  (chk_nxt),
        .data (chk_data)
    );

    always_comb begin
        chk_state_d  = chk_state_q;
        chk_mode_d   = chk_mode_q;
        ref_d        = ref_q;
        locked_d     = locked_q;
        rx_inc       = 1'b0;
        err_inc      = 1'b0;

        if (!enable) begin
            chk_state_d = C_IDLE;
            locked_d    = 1'b0;
        end else begin
            case (chk_state_q)
                C_IDLE: begin
                    chk_mode_d  = mode;
                    chk_state_d = C_SYNC;
                end
                C_SYNC: if (rx_tvalid && !seed_bad) begin
                    ref_d       = chk_nxt;
                    locked_d    = 1'b1;
                    chk_state_d = C_CHECK;
                end
                // The reference always advances from itself, never from the
                // received word, so one bad beat costs exactly one error.
                C_CHECK: if (rx_tvalid) begin
                    ref_d   = chk_nxt;
                    rx_inc  = 1'b1;
                    err_inc = (rx_tdata != chk_data);
                end
                default: chk_state_d = C_IDLE;
            endcase
        end

        rx_cnt_d     = rx_cnt_q;
        err_cnt_d    = err_cnt_q;
        err_sticky_d = err_sticky_q;
        if (clr_stats) begin
            rx_cnt_d     = '0;
            err_cnt_d    = '0;
            err_sticky_d = 1'b0;
        end else begin
            if (rx_inc && (rx_cnt_q != '1))   rx_cnt_d  = rx_cnt_q + 1'b1;
            if (err_inc && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
            if (err_inc)                      err_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge ACLK or negedge rst_n) begin
        if (!rst_n) begin
            chk_state_q  <= C_IDLE;
            chk_mode_q   <= 1'b0;
            ref_q        <= '0;
            locked_q     <= 1'b0;
            rx_cnt_q     <= '0;
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
        end else begin
            chk_state_q  <= chk_state_d;
            chk_mode_q   <= chk_mode_d;
            ref_q        <= ref_d;
            locked_q     <= locked_d;
            rx_cnt_q     <= rx_cnt_d;
            err_cnt_q    <= err_cnt_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    assign rx_tready  = 1'b1;
    assign tx_cnt     = tx_cnt_q;
    assign rx_cnt     = rx_cnt_q;
    assign err_cnt    = err_cnt_q;
    assign err_sticky = err_sticky_q;
    assign locked     = locked_q;

endmodule

// File: doc/qeciphy_traffic_gen_chk.md
QECIPHY_TRAFFIC_GEN_CHK -- requirements
Module: qeciphy_traffic_gen_chk

Interface
REQ-001 SHALL have parameter DATA_W, default 64: TX/RX data width, multiple of 8, min 32.
REQ-002 SHALL have parameter CNT_W, default 32: width of beat and error counters.
REQ-003 SHALL have parameter SEED, default 31'h7FFF_FFFF: PRBS31 reset/restart state, nonzero.
REQ-004 SHALL have port ACLK  in  1  clock for all logic.
REQ-005 SHALL have port rst_n  in  1  reset: asynchronous, active-low.
REQ-006 SHALL have port enable  in  1  generator and checker run when high.
REQ-007 SHALL have port link_up  in  1  PHY ready; generator gated when low.
REQ-008 SHALL have port mode  in  1  0 = incrementing counter, 1 = PRBS31; sampled only in idle.
REQ-009 SHALL have port gap_len  in  8  number of idle cycles inserted after each accepted TX beat.
REQ-010 SHALL have port clr_stats  in  1  synchronous pulse that clears all counters and the sticky flag.
REQ-011 SHALL have ports tx_tdata/tx_tvalid (out, DATA_W/1) and tx_tready (in, 1): AXI-Stream source.
REQ-012 SHALL have ports rx_tdata/rx_tvalid (in, DATA_W/1) and rx_tready (out, 1, tied high): AXI-Stream sink.
REQ-013 SHALL have outputs tx_cnt, rx_cnt, err_cnt (CNT_W each), err_sticky (1) and locked (1).

Function
REQ-014 The generator FSM SHALL have states G_IDLE, G_SEND and G_GAP; it leaves G_IDLE for G_SEND when enable && link_up.
REQ-015 In G_SEND, tx_tvalid SHALL be 1, and tx_tdata SHALL be held stable until tx_tvalid && tx_tready.
REQ-016 On acceptance, the pattern SHALL advance, tx_cnt SHALL increment, and the FSM SHALL go to G_GAP if gap_len != 0, else stay in G_SEND.
REQ-017 G_GAP SHALL last exactly gap_len cycles with tx_tvalid = 0, then return to G_SEND.
REQ-018 Deassertion of enable or link_up SHALL return the FSM to G_IDLE only when tx_tvalid is 0 or the beat is being accepted (no AXI valid retraction).
REQ-019 Counter mode: the first beat SHALL be 0 and each next beat SHALL be previous + 1 modulo 2^DATA_W.
REQ-020 PRBS mode: the state SHALL be the polynomial x^31+x^28+1 stepped once per beat, and data SHALL be the 31-bit state zero-extended to 32 bits and replicated across DATA_W.
REQ-021 Entry to G_IDLE SHALL restart the pattern (counter 0 / SEED).
REQ-022 The checker FSM SHALL have states C_IDLE, C_SYNC and C_CHECK; enable high moves C_IDLE to C_SYNC, and enable low forces C_IDLE.
REQ-023 In C_SYNC, the first rx_tvalid beat SHALL seed the reference (counter: rx_tdata; PRBS: rx_tdata[30:0]), set locked = 1 and move to C_CHECK; this beat SHALL NOT be counted as an error.
REQ-024 In C_CHECK, each rx_tvalid beat SHALL increment rx_cnt and advance the reference; a mismatch SHALL increment err_cnt and set err_sticky.
REQ-025 The result of a compare SHALL appear on the counters 1 cycle after the beat.
REQ-026 After a mismatch the reference SHALL continue from expected, not from received (no resync).
REQ-027 All counters SHALL saturate at 2^CNT_W-1.
REQ-028 When clr_stats coincides with an increment, clear SHALL win and that increment SHALL be dropped.
REQ-029 A PRBS state of zero SHALL never occur; a seed word whose [30:0] is zero SHALL keep the checker in C_SYNC.

Reset
REQ-030 While rst_n is low, all FSMs SHALL be in IDLE and all outputs SHALL be 0 except rx_tready = 1; assertion mid-beat SHALL abort immediately.
REQ-031 After rst_n deasserts, the first tx_tvalid SHALL be no earlier than 2 ACLK cycles later.

Configuration
REQ-032 With macro QECIPHY_TGC_ERR_INJECT_EN defined, the block SHALL add input inject_err (1); a pulse SHALL invert bit 0 of the next accepted TX beat only, with the pattern state unaffected.
REQ-033 Without QECIPHY_TGC_ERR_INJECT_EN, the port and its logic SHALL be absent and TX data SHALL always be pure pattern.

Structure
REQ-034 Package qeciphy_tgc_pkg SHALL hold the mode enum, the generator and checker state enums, the PRBS31 tap constants and the default SEED.
REQ-035 Sub-module qeciphy_tgc_pattern (next-value logic for counter/PRBS) SHALL be instantiated twice: once in the generator and once in the checker.

Verification
REQ-036 Counter mode, gap_len = 0, tx looped to rx, tready = 1, 1000 cycles -> tx data 0,1,2,…; locked = 1; err_cnt = 0; rx_cnt = tx_cnt - 1.
REQ-037 PRBS mode, gap_len = 3 -> tx_tvalid pattern 1,0,0,0 repeating; first word replicates SEED; err_cnt = 0.
REQ-038 tready held low for 5 cycles mid-send -> tx_tdata stable and tx_tvalid held; disabling enable during the stall does not drop tvalid.
REQ-039 With ERR_INJECT_EN, a single inject_err pulse in loopback -> err_cnt = 1 and err_sticky = 1; subsequent beats match.
REQ-040 CNT_W = 4, continuous errors -> err_cnt saturates at 15; clr_stats coinciding with an error -> err_cnt = 0.
REQ-041 rst_n asserted mid-stream -> all outputs 0 in the same cycle; after release, the stream restarts at 0/SEED and the checker resyncs.
